// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and constants for the parking RFID path
package parking_pkg;

  localparam int WIEGAND_FRAME_BITS = 34;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RECV  = 2'b01,
    ST_CHECK = 2'b10
  } wg_state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_LEN    = 2'b01;
  localparam logic [1:0] ERR_PARITY = 2'b10;
  localparam logic [1:0] ERR_COLL   = 2'b11;

endpackage

// File: rtl/wiegand_rfid_receiver_if.sv
// rtl/wiegand_rfid_receiver_if.sv - decoded card-ID result bus
interface wiegand_rfid_receiver_if #(
  parameter int DATA_BITS = 32
);
  logic [DATA_BITS-1:0] rfid_tag;
  logic                 tag_valid;
  logic                 frame_error;
  logic [1:0]           err_code;
  logic                 busy;

  modport master (output rfid_tag, output tag_valid, output frame_error, output err_code, output busy);
  modport slave  (input  rfid_tag, input  tag_valid, input  frame_error, input  err_code, input  busy);
endinterface

// File: rtl/wiegand_edge_sync.sv
// rtl/wiegand_edge_sync.sv - synchronizer and falling-edge detect for one Wiegand line
module wiegand_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic fall,
  output logic low
);
  logic [SYNC_STAGES-1:0] sync_q;

  // Lines idle high, so the chain resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      fall   <= 1'b0;
      low    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line};
      fall   <= ~sync_q[SYNC_STAGES-1] & ~low;
      low    <= ~sync_q[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/wiegand_rfid_receiver.sv
// rtl/wiegand_rfid_receiver.sv - Wiegand frame decoder with length, parity and collision checks
module wiegand_rfid_receiver
  import parking_pkg::*;
#(
  parameter int DATA_BITS   = WIEGAND_FRAME_BITS - 2,
  parameter int GAP_CYCLES  = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic wg_d0,
  input  logic wg_d1,
  wiegand_rfid_receiver_if.master rx
);
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int CNT_W      = $clog2(DATA_BITS + 4);
  localparam int GAP_W      = $clog2(GAP_CYCLES + 1);

  logic fall0, fall1, low0, low1;
  logic both_low, bit_event;
  wg_state_t state_q, state_d;

  logic [FRAME_BITS-1:0] sr_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [GAP_W-1:0]      gap_q;
  logic                  coll_q;

  logic [DATA_BITS-1:0]  tag_q;
  logic                  tag_valid_q, frame_error_q;
  logic [1:0]            err_code_q;

  logic [DATA_BITS-1:0]  data_field;
  logic                  even_ok, odd_ok;
  logic [1:0]            chk_code;
  logic                  busy;

  wiegand_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d0 (
    .clk(clk), .reset(reset), .line(wg_d0), .fall(fall0), .low(low0));
  wiegand_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_d1 (
    .clk(clk), .reset(reset), .line(wg_d1), .fall(fall1), .low(low1));

  assign both_low  = low0 & low1;
  assign bit_event = (fall0 ^ fall1) & ~both_low;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bit_event) state_d = ST_RECV;
      ST_RECV:  if (!bit_event && gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_CHECK;
      ST_CHECK: state_d = bit_event ? ST_RECV : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_field = sr_q[FRAME_BITS-2:1];
    even_ok    = ~(sr_q[FRAME_BITS-1] ^ (^data_field[DATA_BITS-1:DATA_BITS/2]));
    odd_ok     = sr_q[0] ^ (^data_field[DATA_BITS/2-1:0]);
    busy       = (state_q != ST_IDLE);
    chk_code   = ERR_NONE;
    if (coll_q)                                  chk_code = ERR_COLL;
    else if (bit_cnt_q != CNT_W'(FRAME_BITS))    chk_code = ERR_LEN;
    else if (!even_ok || !odd_ok)                chk_code = ERR_PARITY;
  end

  // The frame under check is judged from current state, so a new frame may start in CHECK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      coll_q    <= 1'b0;
    end else begin
      if (bit_event && state_q != ST_RECV) begin
        sr_q      <= {{(FRAME_BITS-1){1'b0}}, fall1};
        bit_cnt_q <= CNT_W'(1);
        gap_q     <= '0;
      end else if (bit_event) begin
        sr_q      <= {sr_q[FRAME_BITS-2:0], fall1};
        bit_cnt_q <= (bit_cnt_q == CNT_W'(DATA_BITS + 3)) ? bit_cnt_q : bit_cnt_q + 1'b1;
        gap_q     <= '0;
      end else if (state_q == ST_RECV) begin
        gap_q <= gap_q + 1'b1;
      end
      if (state_q == ST_CHECK) coll_q <= both_low;
      else if (both_low)       coll_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q         <= '0;
      tag_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      tag_valid_q   <= (state_q == ST_CHECK) && (chk_code == ERR_NONE);
      frame_error_q <= (state_q == ST_CHECK) && (chk_code != ERR_NONE);
      if (state_q == ST_CHECK) begin
        err_code_q <= chk_code;
        if (chk_code == ERR_NONE) tag_q <= data_field;
      end
    end
  end

  assign rx.rfid_tag    = tag_q;
  assign rx.tag_valid   = tag_valid_q;
  assign rx.frame_error = frame_error_q;
  assign rx.err_code    = err_code_q;
  assign rx.busy        = busy;
endmodule
